unified_mem_arbiter: RTL
========================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: byte-address width; the memory SHALL hold 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter STARVE_MAX, default 4, range 1..15: number of consecutive fetch denials that forces a fetch grant.
REQ-003 clk  input  1: single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1: reset, synchronous and active-low.
REQ-005 if_req  input  1: instruction fetch request.
REQ-006 if_addr  input  ADDR_W: fetch byte address; bits [1:0] are ignored.
REQ-007 if_rdata  output  32: fetched word.
REQ-008 if_valid  output  1: if_rdata is valid this cycle.
REQ-009 stall_if  output  1: combinational; the fetch request this cycle is not granted.
REQ-010 d_req  input  1: data access request.
REQ-011 d_we  input  1: 1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_W: data byte address.
REQ-013 d_func3  input  3: RV32 load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-014 d_wdata  input  32: store data, right-aligned.
REQ-015 d_rdata  output  32: load result, sign- or zero-extended.
REQ-016 d_valid  output  1: d_rdata/d_err are valid this cycle; also pulses for stores.
REQ-017 stall_d  output  1: combinational; the data request this cycle is not granted.
REQ-018 d_err  output  1: the access this response refers to was misaligned or had an illegal funct3.

Function
REQ-019 Single memory port: at most one access SHALL be granted per cycle.
REQ-020 Arbitration: when only one port requests, that port SHALL be granted.
REQ-021 When both ports request, data SHALL be granted, unless starve_cnt == STARVE_MAX, in which case fetch SHALL be granted.
REQ-022 starve_cnt (4 bits) SHALL increment on each cycle in which fetch is denied.
REQ-023 starve_cnt SHALL clear on any fetch grant, and SHALL clear on any cycle without if_req.
REQ-024 stall_if = if_req & ~fetch_grant; stall_d = d_req & ~data_grant. Requesters SHALL hold their inputs stable while stalled.
REQ-025 Latency: a granted access at edge N SHALL produce if_valid or d_valid high for exactly the cycle following edge N.
REQ-026 Response outputs (if_rdata, d_rdata, d_err) SHALL be registered and SHALL hold their value until the next response on that port.
REQ-027 Fetch: if_rdata = word at if_addr[ADDR_W-1:2].
REQ-028 Store byte lanes: SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all four lanes; unaddressed lanes SHALL be unchanged.
REQ-029 Load: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the addressed byte or halfword; LW SHALL return the full word.
REQ-030 Error cases: halfword with addr[0]=1, word with addr[1:0]!=0, funct3 011/110/111, or store with funct3 1xx.
REQ-031 On an error case, the access SHALL be granted and SHALL consume the port, no write SHALL occur, and the response SHALL be d_valid=1, d_err=1, d_rdata=0.
REQ-032 Store response: d_valid=1, d_err=0, and d_rdata SHALL be unchanged.
REQ-033 A load at the address of a store in the immediately preceding cycle SHALL return the newly written data.

Reset
REQ-034 While rst=0 at a rising edge, the following SHALL clear: if_valid, d_valid, d_err, if_rdata, d_rdata, and starve_cnt.
REQ-035 During reset, no write SHALL occur; stall_if and stall_d SHALL be 0.
REQ-036 Any response due in the cycle after a reset edge SHALL be dropped.
REQ-037 Memory contents SHALL NOT be cleared by reset.
REQ-038 After rst returns to 1, the first request SHALL be granted on the same edge.

Verification
REQ-039 Scenario: SW 0xDEADBEEF @0x10, then LB @0x13, LBU @0x13, LH @0x12 -> d_rdata 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD.
REQ-040 Scenario: SB 0x55 @0x21 over a word holding 0x11223344 -> LW @0x20 returns 0x11225544.
REQ-041 Scenario: if_req and d_req held high for 10 cycles with STARVE_MAX=4 -> grants DDDDF DDDDF; stall_if high for 8 cycles, stall_d high for 2.
REQ-042 Scenario: LH @0x03 and SW @0x06 -> each gives d_valid=1, d_err=1, d_rdata=0; the word @0x04 is unchanged.
REQ-043 Scenario: rst=0 asserted on the cycle after a granted LW -> no d_valid in the following cycle; all outputs 0.
REQ-044 Scenario: fetch-only stream @0x00,0x04,0x08 -> if_valid on 3 consecutive cycles, stall_if never high.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Single-port word memory shared by instruction fetch and RV32
//            load/store traffic, with data priority and fetch anti-starvation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_func3,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              stall_d,
  output logic              d_err
);

  localparam int         c_DEPTH  = 1 << (ADDR_W - 2);
  localparam logic [3:0] c_STARVE = 4'(STARVE_MAX);

  logic [31:0]       r_mem [c_DEPTH];
  logic [3:0]        r_starve;

  logic              w_fetch_grant;
  logic              w_data_grant;
  logic [ADDR_W-3:0] w_if_idx;
  logic [ADDR_W-3:0] w_d_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_d_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic [31:0]       w_load;
  logic              w_wr;
  logic              w_unused;

  assign w_if_idx = if_addr[ADDR_W-1:2];
  assign w_d_idx  = d_addr[ADDR_W-1:2];
  assign w_lane   = d_addr[1:0];
  assign w_unused = &{1'b0, if_addr[1:0]};

  // Grants are forced low while in reset so nothing is written or answered.
  assign w_fetch_grant = rst & if_req & (~d_req | (r_starve == c_STARVE));
  assign w_data_grant  = rst & d_req & ~w_fetch_grant;
  assign stall_if      = rst & if_req & ~w_fetch_grant;
  assign stall_d       = rst & d_req & ~w_data_grant;

  assign w_d_word = r_mem[w_d_idx];
  assign w_byte   = w_d_word[8*w_lane +: 8];
  assign w_half   = d_addr[1] ? w_d_word[31:16] : w_d_word[15:0];

  always_comb begin
    w_err    = 1'b0;
    w_be     = 4'b0000;
    w_wlanes = 32'h0;
    w_load   = 32'h0;
    case (d_func3)
      3'b000: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{d_wdata[7:0]}};
        w_load   = {{24{w_byte[7]}}, w_byte};
      end
      3'b100: begin
        w_err  = d_we;
        w_load = {24'h0, w_byte};
      end
      3'b001: begin
        w_err    = d_addr[0];
        w_be     = d_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{d_wdata[15:0]}};
        w_load   = {{16{w_half[15]}}, w_half};
      end
      3'b101: begin
        w_err  = d_addr[0] | d_we;
        w_load = {16'h0, w_half};
      end
      3'b010: begin
        w_err    = |d_addr[1:0];
        w_be     = 4'b1111;
        w_wlanes = d_wdata;
        w_load   = w_d_word;
      end
      default: w_err = 1'b1;
    endcase
  end

  assign w_wr = w_data_grant & d_we & ~w_err;

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_d_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_rdata <= 32'h0;
      d_valid  <= 1'b0;
      d_rdata  <= 32'h0;
      d_err    <= 1'b0;
      r_starve <= 4'h0;
    end else begin
      if_valid <= w_fetch_grant;
      if (w_fetch_grant) if_rdata <= r_mem[w_if_idx];
      d_valid <= w_data_grant;
      if (w_data_grant) begin
        if (w_err) begin
          d_err   <= 1'b1;
          d_rdata <= 32'h0;
        end else begin
          d_err <= 1'b0;
          if (!d_we) d_rdata <= w_load;
        end
      end
      if (!if_req || w_fetch_grant) r_starve <= 4'h0;
      else if (r_starve != 4'hF)    r_starve <= r_starve + 4'h1;
    end
  end

endmodule

`default_nettype wire
